rv32i_reg_file: RTL and testbench
=================================

RV32I_REG_FILE -- requirements
Module: rv32i_reg_file

Interface
REQ-001 Parameter BYPASS, default 1, meaning 1 = same-cycle write-to-read forwarding, 0 = read returns stored value.
REQ-002 Parameter CLEAR_START, default 1, meaning first register index cleared by the clear sequence; registers below it are left untouched.
REQ-003 CLK  input  1  system clock, all state updates on rising edge.
REQ-004 nRST  input  1  reset, synchronous and active-low.
REQ-005 rf  rv32i_reg_file_if.rf  -  pipeline port: inputs w_data, rs1, rs2, rd, wen; outputs rs1_data, rs2_data.
REQ-006 clr_req  input  1  one-cycle pulse starting the clear sequence.
REQ-007 busy  output  1  high while the clear sequence runs; the core stalls on it.
REQ-008 dbg_req  input  1  debug access request, held high until dbg_ack.
REQ-009 dbg_wen  input  1  debug access type: 1 = write, 0 = read.
REQ-010 dbg_addr  input  5  debug register index (regsel_t).
REQ-011 dbg_wdata  input  32  debug write data (word_t).
REQ-012 dbg_rdata  output  32  debug read data, valid when dbg_ack = 1.
REQ-013 dbg_ack  output  1  one-cycle completion pulse for a debug access.

Function
REQ-014 Storage: 31 x 32-bit registers x1..x31; x0 has no storage, reads return 0, writes to x0 are discarded.
REQ-015 Pipeline write: when wen=1, rd!=0 and state != CLEAR, reg[rd] <= w_data at the rising edge.
REQ-016 Pipeline read: rs1_data/rs2_data are combinational from rs1/rs2, zero-latency.
REQ-017 Bypass (BYPASS=1): when wen=1, rd!=0, state != CLEAR and rsN==rd, rsN_data = w_data in the same cycle.
REQ-018 FSM states: IDLE, DBG_RESP, CLEAR; encoding is a shared enum.
REQ-019 IDLE -> CLEAR on clr_req=1; clr_req takes priority over dbg_req in the same cycle.
REQ-020 CLEAR: a 5-bit counter starts at CLEAR_START and zeroes reg[counter] each cycle; counter = 31 -> IDLE, giving (32 - CLEAR_START) cycles with busy=1.
REQ-021 During CLEAR: pipeline writes are dropped, clr_req is ignored, dbg_req is not accepted, and reads return stored contents without bypass.
REQ-022 Debug accept: in IDLE with dbg_req=1, a read is accepted unconditionally; a write is accepted only if no pipeline write with rd!=0 occurs that cycle (the pipeline has priority).
REQ-023 Accepted debug write: reg[dbg_addr] <= dbg_wdata at that edge (discarded if dbg_addr=0); the bypass does not forward debug writes.
REQ-024 Accepted debug read: dbg_rdata is registered from reg[dbg_addr] (0 for x0) at the accept edge.
REQ-025 Debug handshake: dbg_ack=1 for exactly the one cycle after accept (state DBG_RESP); DBG_RESP -> IDLE unconditionally, so the earliest next accept is accept+2.
REQ-026 dbg_rdata holds its value until the next accepted read; after a write its value is don't-care but stable.
REQ-027 A pipeline write and a debug read of the same register in the same cycle: dbg_rdata returns the pre-write value.

Reset
REQ-028 With nRST=0 at a rising edge: all registers 0, state IDLE, counter 0, busy=0, dbg_ack=0, dbg_rdata=0.
REQ-029 Reset during CLEAR or DBG_RESP aborts the operation; no ack is issued afterwards.

Structure
REQ-030 word_t, regsel_t and the FSM enum rf_state_t are defined in rv32i_types_pkg; no other new package is added.
REQ-031 The design is a single module with no sub-modules; the storage array and the FSM live in it.

Verification
REQ-032 The bench covers the following five scenarios.
- Write rd=5, w_data=0xDEADBEEF, then read rs1=5 next cycle -> rs1_data=0xDEADBEEF; write rd=0, 0x1234 -> rs1=0 reads 0.
- Same cycle: wen=1, rd=7, w_data=0xA5A5A5A5, rs2=7 -> rs2_data=0xA5A5A5A5 (BYPASS=1); with BYPASS=0 -> old value.
- Load x1..x31 with nonzero values, pulse clr_req -> busy high for exactly 31 cycles, then all reads return 0; a wen during busy has no effect.
- Debug write x10=0x55 while the pipeline writes rd=3 -> no ack that cycle; ack one cycle after the pipeline idles; a debug read of x10 -> dbg_rdata=0x55 with dbg_ack a single-cycle pulse.
- Assert nRST=0 mid-CLEAR (counter=12) -> next cycle busy=0, all registers 0, IDLE; dbg_req then accepted normally.

Source files
------------

// File: rtl/rv32i_types_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rv32i_types_pkg                                       |
// | Brief    : Shared types for the RV32I register file: data word,  |
// |            register selector and register-file FSM states.       |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package rv32i_types_pkg;

  localparam int XLEN     = 32;
  localparam int SEL_BITS = 5;

  typedef logic [XLEN-1:0]     word_t;
  typedef logic [SEL_BITS-1:0] regsel_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DBG_RESP = 2'd1,
    CLEAR    = 2'd2
  } rf_state_t;

endpackage
`default_nettype wire

// File: rtl/rv32i_reg_file_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rv32i_reg_file_if                                     |
// | Brief    : Pipeline port of the register file: one write port    |
// |            and two combinational read ports.                     |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
interface rv32i_reg_file_if;
  import rv32i_types_pkg::*;

  word_t   w_data;
  regsel_t rs1;
  regsel_t rs2;
  regsel_t rd;
  logic    wen;
  word_t   rs1_data;
  word_t   rs2_data;

  // Register-file side (slave)
  modport rf (
    input  w_data, rs1, rs2, rd, wen,
    output rs1_data, rs2_data
  );

  // Core side (master)
  modport core (
    output w_data, rs1, rs2, rd, wen,
    input  rs1_data, rs2_data
  );

endinterface
`default_nettype wire

// File: rtl/rv32i_reg_file.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : rv32i_reg_file                                        |
// | Brief    : RV32I integer register file (x1..x31, x0 hardwired    |
// |            to zero) with optional write-to-read forwarding, a    |
// |            multi-cycle clear sequence and a debug access port.   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module rv32i_reg_file
  import rv32i_types_pkg::*;
#(
  parameter int BYPASS      = 1,
  parameter int CLEAR_START = 1
) (
  input  logic                CLK,
  input  logic                nRST,
  rv32i_reg_file_if.rf        rf,
  input  logic                clr_req,
  output logic                busy,
  input  logic                dbg_req,
  input  logic                dbg_wen,
  input  regsel_t             dbg_addr,
  input  word_t               dbg_wdata,
  output word_t               dbg_rdata,
  output logic                dbg_ack
);

  rf_state_t r_state;
  rf_state_t w_state_next;
  regsel_t   r_clr_cnt;
  word_t     r_regs [1:31];
  word_t     w_view [0:31];
  word_t     r_dbg_rdata;
  logic      w_clearing;
  logic      w_pipe_we;
  logic      w_dbg_accept;
  logic      w_dbg_we;

  assign w_clearing = (r_state == CLEAR);
  assign w_pipe_we  = rf.wen && (rf.rd != '0) && !w_clearing;
  assign w_dbg_we   = w_dbg_accept && dbg_wen;

  assign busy      = w_clearing;
  assign dbg_ack   = (r_state == DBG_RESP);
  assign dbg_rdata = r_dbg_rdata;

  // Architectural view of all 32 registers, x0 reading as zero
  always_comb begin
    w_view[0] = '0;
    for (int i = 1; i < 32; i++) begin
      w_view[i] = r_regs[i];
    end
  end

  // Read ports: stored value, replaced by the in-flight pipeline write when forwarding is on
  always_comb begin
    rf.rs1_data = w_view[rf.rs1];
    rf.rs2_data = w_view[rf.rs2];
    if ((BYPASS != 0) && w_pipe_we && (rf.rs1 == rf.rd)) begin
      rf.rs1_data = rf.w_data;
    end
    if ((BYPASS != 0) && w_pipe_we && (rf.rs2 == rf.rd)) begin
      rf.rs2_data = rf.w_data;
    end
  end

  // Next-state logic; a clear request wins over a debug request, and a debug
  // write yields to a pipeline write landing in the same cycle
  always_comb begin
    w_state_next = r_state;
    w_dbg_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (clr_req) begin
          w_state_next = CLEAR;
        end else if (dbg_req && (!dbg_wen || !w_pipe_we)) begin
          w_dbg_accept = 1'b1;
          w_state_next = DBG_RESP;
        end
      end
      DBG_RESP: w_state_next = IDLE;
      CLEAR: begin
        if (r_clr_cnt == 5'd31) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Clear index: loaded on entry, then walks up to x31
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_clr_cnt <= '0;
    end else if ((r_state == IDLE) && clr_req) begin
      r_clr_cnt <= regsel_t'(CLEAR_START);
    end else if (w_clearing) begin
      r_clr_cnt <= r_clr_cnt + 5'd1;
    end
  end

  // Storage update: clear zeroing, else pipeline write, else accepted debug write
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 1; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (w_clearing) begin
          if (r_clr_cnt == 5'(i)) begin
            r_regs[i] <= '0;
          end
        end else if (w_pipe_we && (rf.rd == 5'(i))) begin
          r_regs[i] <= rf.w_data;
        end else if (w_dbg_we && (dbg_addr == 5'(i))) begin
          r_regs[i] <= dbg_wdata;
        end
      end
    end
  end

  // Debug read data captured from the stored (pre-write) value at the accept edge
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_dbg_rdata <= '0;
    end else if (w_dbg_accept && !dbg_wen) begin
      r_dbg_rdata <= w_view[dbg_addr];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rv32i_reg_file.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_rv32i_reg_file                                     |
// | Brief    : Self-checking bench: two instances (forwarding on and |
// |            off) fed the same stimulus, compared against a        |
// |            behavioural model of the register file.               |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_rv32i_reg_file;
  import rv32i_types_pkg::*;

  localparam int CLEAR_START = 1;

  logic        CLK;
  logic        nRST;
  logic        clr_req;
  logic        dbg_req;
  logic        dbg_wen;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        busy0, busy1;
  logic        dbg_ack0, dbg_ack1;
  logic [31:0] dbg_rdata0, dbg_rdata1;

  rv32i_reg_file_if rf0 ();
  rv32i_reg_file_if rf1 ();

  assign rf1.w_data = rf0.w_data;
  assign rf1.rs1    = rf0.rs1;
  assign rf1.rs2    = rf0.rs2;
  assign rf1.rd     = rf0.rd;
  assign rf1.wen    = rf0.wen;

  rv32i_reg_file #(.BYPASS(1), .CLEAR_START(CLEAR_START)) dut_byp (
    .CLK(CLK), .nRST(nRST), .rf(rf0), .clr_req(clr_req), .busy(busy0),
    .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata0), .dbg_ack(dbg_ack0)
  );

  rv32i_reg_file #(.BYPASS(0), .CLEAR_START(CLEAR_START)) dut_nobyp (
    .CLK(CLK), .nRST(nRST), .rf(rf1), .clr_req(clr_req), .busy(busy1),
    .dbg_req(dbg_req), .dbg_wen(dbg_wen), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata1), .dbg_ack(dbg_ack1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model: register contents plus clear / debug-response bookkeeping
  logic [31:0] m_regs [32];
  int          m_clear_left;
  int          m_clear_idx;
  bit          m_ack;
  logic [31:0] m_rdata;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] rs, input bit byp);
    if (rs == 5'd0) return 32'd0;
    if (byp && m_clear_left == 0 && rf0.wen && rf0.rd != 5'd0 && rf0.rd == rs) return rf0.w_data;
    return m_regs[rs];
  endfunction

  task automatic model_update();
    bit pipe;
    if (!nRST) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_clear_left = 0;
      m_clear_idx  = 0;
      m_ack        = 1'b0;
      m_rdata      = 32'd0;
      return;
    end
    pipe = rf0.wen && rf0.rd != 5'd0 && m_clear_left == 0;
    if (m_clear_left > 0) begin
      m_regs[m_clear_idx] = 32'd0;
      m_clear_idx++;
      m_clear_left--;
    end else if (m_ack) begin
      m_ack = 1'b0;
      if (pipe) m_regs[rf0.rd] = rf0.w_data;
    end else begin
      if (clr_req) begin
        m_clear_left = 32 - CLEAR_START;
        m_clear_idx  = CLEAR_START;
      end else if (dbg_req && (!dbg_wen || !pipe)) begin
        m_ack = 1'b1;
        if (dbg_wen) begin
          if (dbg_addr != 5'd0) m_regs[dbg_addr] = dbg_wdata;
        end else begin
          m_rdata = m_regs[dbg_addr];
        end
      end
      if (pipe) m_regs[rf0.rd] = rf0.w_data;
    end
  endtask

  task automatic check_outputs();
    chk("rs1_byp",    rf0.rs1_data, exp_rd(rf0.rs1, 1'b1));
    chk("rs2_byp",    rf0.rs2_data, exp_rd(rf0.rs2, 1'b1));
    chk("rs1_nobyp",  rf1.rs1_data, exp_rd(rf0.rs1, 1'b0));
    chk("rs2_nobyp",  rf1.rs2_data, exp_rd(rf0.rs2, 1'b0));
    chk("busy",       {31'd0, busy0},    {31'd0, m_clear_left > 0});
    chk("busy_nobyp", {31'd0, busy1},    {31'd0, m_clear_left > 0});
    chk("dbg_ack",    {31'd0, dbg_ack0}, {31'd0, m_ack});
    chk("dbg_rdata",  dbg_rdata0, m_rdata);
    chk("dbg_rdata1", dbg_rdata1, m_rdata);
  endtask

  // One clock: check settled outputs, clock the DUTs and the model, return at the falling edge
  task automatic step();
    #1;
    check_outputs();
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic pipe_write(input logic [4:0] rd, input logic [31:0] data);
    rf0.wen = 1'b1; rf0.rd = rd; rf0.w_data = data;
    step();
    rf0.wen = 1'b0;
  endtask

  initial begin
    int busy_cnt;
    logic [31:0] old7;

    nRST = 1'b0; clr_req = 1'b0;
    dbg_req = 1'b0; dbg_wen = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    rf0.wen = 1'b0; rf0.rd = '0; rf0.rs1 = '0; rf0.rs2 = '0; rf0.w_data = '0;
    @(posedge CLK); model_update(); @(negedge CLK);
    step();
    nRST = 1'b1;

    // Reset state: every register reads zero
    for (int i = 0; i < 32; i += 2) begin
      rf0.rs1 = 5'(i); rf0.rs2 = 5'(i + 1);
      step();
    end
    chk("reset_busy", {31'd0, busy0}, 32'd0);
    chk("reset_rdata", dbg_rdata0, 32'd0);

    // Write then read back; writes to x0 are discarded
    pipe_write(5'd5, 32'hDEADBEEF);
    rf0.rs1 = 5'd5;
    #1 chk("s1_read_x5", rf0.rs1_data, 32'hDEADBEEF);
    step();
    rf0.rs1 = 5'd0;
    pipe_write(5'd0, 32'h00001234);
    #1 chk("s1_read_x0", rf0.rs1_data, 32'd0);
    step();

    // Same-cycle forwarding vs stored value
    old7 = 32'h11112222;
    pipe_write(5'd7, old7);
    rf0.wen = 1'b1; rf0.rd = 5'd7; rf0.w_data = 32'hA5A5A5A5; rf0.rs2 = 5'd7;
    #1;
    chk("s2_bypass_on",  rf0.rs2_data, 32'hA5A5A5A5);
    chk("s2_bypass_off", rf1.rs2_data, old7);
    step();
    rf0.wen = 1'b0;
    step();

    // Clear sequence: fill all, clear, busy count, writes dropped, all zero afterwards
    for (int i = 1; i < 32; i++) pipe_write(5'(i), $urandom | 32'h1);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    busy_cnt = 0;
    for (int k = 0; k < 40 && busy0; k++) begin
      rf0.wen = 1'b1; rf0.rd = 5'($urandom_range(1, 31)); rf0.w_data = $urandom | 32'h1;
      rf0.rs1 = 5'($urandom_range(0, 31)); rf0.rs2 = rf0.rd;
      clr_req = ($urandom_range(0, 3) == 0);
      busy_cnt++;
      step();
    end
    clr_req = 1'b0; rf0.wen = 1'b0;
    chk("s3_busy_cycles", 32'(busy_cnt), 32'd31);
    for (int i = 1; i < 32; i++) begin
      rf0.rs1 = 5'(i); rf0.rs2 = 5'(32 - i);
      step();
      chk("s3_cleared", rf0.rs1_data, 32'd0);
    end

    // Debug write blocked by a pipeline write, then completed; then debug read
    rf0.wen = 1'b1; rf0.rd = 5'd3; rf0.w_data = 32'h33333333;
    dbg_req = 1'b1; dbg_wen = 1'b1; dbg_addr = 5'd10; dbg_wdata = 32'h55;
    step();
    chk("s4_no_ack_blocked", {31'd0, dbg_ack0}, 32'd0);
    rf0.wen = 1'b0;
    step();
    chk("s4_ack_write", {31'd0, dbg_ack0}, 32'd1);
    dbg_req = 1'b0;
    rf0.rs1 = 5'd10;
    step();
    chk("s4_x10", rf0.rs1_data, 32'h55);
    dbg_req = 1'b1; dbg_wen = 1'b0; dbg_addr = 5'd10;
    step();
    chk("s4_ack_read", {31'd0, dbg_ack0}, 32'd1);
    chk("s4_rdata", dbg_rdata0, 32'h55);
    dbg_req = 1'b0;
    step();
    chk("s4_ack_pulse", {31'd0, dbg_ack0}, 32'd0);

    // Reset in the middle of a clear (counter at 12)
    for (int i = 1; i < 32; i++) pipe_write(5'(i), 32'(i) * 32'h01010101);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 11; k++) step();
    chk("s5_busy_mid", {31'd0, busy0}, 32'd1);
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    chk("s5_busy_after_rst", {31'd0, busy0}, 32'd0);
    for (int i = 1; i < 32; i++) begin
      rf0.rs1 = 5'(i); rf0.rs2 = 5'(i);
      step();
      chk("s5_zero", rf0.rs1_data, 32'd0);
    end
    dbg_req = 1'b1; dbg_wen = 1'b0; dbg_addr = 5'd20;
    step();
    chk("s5_dbg_ack", {31'd0, dbg_ack0}, 32'd1);
    dbg_req = 1'b0;
    step();

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      rf0.wen    = $urandom_range(0, 1);
      rf0.rd     = 5'($urandom_range(0, 31));
      rf0.w_data = $urandom;
      rf0.rs1    = ($urandom_range(0, 2) == 0) ? rf0.rd : 5'($urandom_range(0, 31));
      rf0.rs2    = ($urandom_range(0, 2) == 0) ? rf0.rd : 5'($urandom_range(0, 31));
      if (m_ack) dbg_req = 1'b0;
      else if (!dbg_req && $urandom_range(0, 3) == 0) begin
        dbg_req   = 1'b1;
        dbg_wen   = $urandom_range(0, 1);
        dbg_addr  = 5'($urandom_range(0, 31));
        dbg_wdata = $urandom;
      end
      clr_req = (m_clear_left == 0 && !m_ack && $urandom_range(0, 59) == 0);
      nRST    = ($urandom_range(0, 199) != 0);
      step();
    end
    nRST = 1'b1; clr_req = 1'b0; dbg_req = 1'b0; rf0.wen = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
